// File: rtl/clk_pkg.sv
// Shared clock constants for the 50 MHz game fabric: named divisors, tap
// indices and a frequency-to-divisor helper.
package clk_pkg;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned FALL_DIV_SLOW = 12_500_000;
  localparam int unsigned FALL_DIV_FAST = 3_125_000;
  localparam int unsigned SEG_TAP       = 16;
  localparam int unsigned PIX_TAP       = 1;

  // Divisor whose tgl output runs at hz (tgl period is 2*div clocks).
  function automatic int unsigned hz_to_div(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: period counter, live divisor, one-deep pending divisor,
// registered tick pulse and 50%-duty toggle.
module tick_channel
  import clk_pkg::*;
#(
  parameter int unsigned      CNT_W   = 32,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(FALL_DIV_SLOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             wr_stb_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             tgl_o,
  output logic             pend_vld_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tgl_q, tgl_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             boundary;

  assign wrap     = en_i && (cnt_q == div_q - ONE);
  assign boundary = clr_i || !en_i || wrap;

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    tgl_d      = tgl_q;
    tick_d     = 1'b0;

    if (clr_i) begin
      cnt_d = '0;
      tgl_d = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        tgl_d  = ~tgl_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    // Only a write pending before this cycle may load; the new period restarts at 0.
    if (pend_vld_q && boundary) begin
      div_d      = pend_div_q;
      pend_vld_d = 1'b0;
      cnt_d      = '0;
    end

    if (wr_stb_i) begin
      pend_div_d = (wr_div_i == '0) ? ONE : wr_div_i;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= DEF_DIV;
      pend_div_q <= DEF_DIV;
      pend_vld_q <= 1'b0;
      tgl_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      tgl_q      <= tgl_d;
      tick_q     <= tick_d;
    end
  end

  assign tick_o     = tick_q;
  assign tgl_o      = tgl_q;
  assign pend_vld_o = pend_vld_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable clock-enable generator with a free-running tap counter.
// Write port: a divisor write transfers when wr_valid && wr_ready; wr_ready is low while the addressed channel already holds a pending divisor.
module tick_gen_multi
  import clk_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TAP_W   = 17,
  parameter int unsigned DEF_DIV = FALL_DIV_SLOW,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] tgl,
  output logic [TAP_W-1:0]  taps
);

  logic [NUM_CH-1:0] pend_vld;
  logic [NUM_CH-1:0] wr_stb;
  logic [TAP_W-1:0]  taps_q, taps_d;

  assign wr_ready = ~pend_vld[wr_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_stb[i] = wr_valid && wr_ready && (wr_ch == CH_W'(i));

    tick_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (CNT_W'(DEF_DIV))
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_i       (ch_en[i]),
      .clr_i      (ch_clr[i]),
      .wr_stb_i   (wr_stb[i]),
      .wr_div_i   (wr_div),
      .tick_o     (tick[i]),
      .tgl_o      (tgl[i]),
      .pend_vld_o (pend_vld[i])
    );
  end

  // Free-running; wraps naturally at 2^TAP_W.
  assign taps_d = taps_q + TAP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) taps_q <= '0;
    else     taps_q <= taps_d;
  end

  assign taps = taps_q;

endmodule
